fifo_wr_packer: RTL



---
 rtl/fifo_wr_packer_if.sv | 31 +++
 rtl/fifo_wr_packer.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_wr_packer_if.sv
// Byte-stream input and FIFO write-side signals for fifo_wr_packer.
// FIFO_PACKER_KEEP_EN widens wdata by a RATIO-bit lane-valid mask at the MSB end.
interface fifo_wr_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
`ifdef FIFO_PACKER_KEEP_EN
  localparam int WD = IN_W * RATIO + RATIO;
`else
  localparam int WD = IN_W * RATIO;
`endif

  logic            s_valid;
  logic [IN_W-1:0] s_data;
  logic            s_last;
  logic            s_ready;
  logic            wfull;
  logic            winc;
  logic [WD-1:0]   wdata;

  // master: the beat source together with the FIFO full flag
  modport master (
    output s_valid, s_data, s_last, wfull,
    input  s_ready, winc, wdata
  );

  modport slave (
    input  s_valid, s_data, s_last, wfull,
    output s_ready, winc, wdata
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats little-endian into one async-FIFO word; s_last flushes a zero-padded partial word.
// FIFO_PACKER_KEEP_EN adds a lane-valid mask above the data bits of every written word.
module fifo_wr_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = 16
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_packer_if.slave    bus,
  output logic               busy,
  output logic [CNT_W-1:0]   word_cnt
);
  localparam int DW    = IN_W * RATIO;
  localparam int IDX_W = $clog2(RATIO);
`ifdef FIFO_PACKER_KEEP_EN
  localparam int WD = DW + RATIO;
`else
  localparam int WD = DW;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [DW-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WD-1:0]    hold_data_q, hold_data_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             accept;
  logic             complete;
  logic             winc;
  logic [DW-1:0]    merged;
  logic [RATIO-1:0] lane_mask;
  logic [WD-1:0]    done_word;

  assign winc         = hold_valid_q && !bus.wfull;
  assign bus.winc     = winc;
  assign bus.wdata    = hold_data_q;
  assign bus.s_ready  = !hold_valid_q || !bus.wfull;
  assign accept       = bus.s_valid && bus.s_ready;
  assign complete     = accept && ((idx_q == LAST_IDX) || bus.s_last);
  assign busy         = (idx_q != '0) || hold_valid_q;
  assign word_cnt     = word_cnt_q;

  // Lanes above idx are still zero in acc, so merging the current lane yields the padded word.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign merged[gi*IN_W +: IN_W] = (idx_q == IDX_W'(gi)) ? bus.s_data
                                                           : acc_q[gi*IN_W +: IN_W];
    assign lane_mask[gi] = (IDX_W'(gi) <= idx_q);
  end

`ifdef FIFO_PACKER_KEEP_EN
  assign done_word = {lane_mask, merged};
`else
  assign done_word = merged;
`endif

  always_comb begin
    acc_d        = acc_q;
    idx_d        = idx_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    word_cnt_d   = word_cnt_q;

    if (winc) begin
      hold_valid_d = 1'b0;
      word_cnt_d   = word_cnt_q + CNT_W'(1);
    end

    // A word completing in the same cycle as a FIFO write replaces the departing one.
    if (complete) begin
      hold_valid_d = 1'b1;
      hold_data_d  = done_word;
      acc_d        = '0;
      idx_d        = '0;
    end else if (accept) begin
      acc_d = merged;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      acc_q        <= '0;
      idx_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      word_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  // lane_mask only reaches an output when the keep mask is compiled in
  logic unused_mask;
  assign unused_mask = ^lane_mask;
endmodule
